v_hier_drv: RTL

//  Stimulus/response end of the v_hier_sub avec->qvec interface.

---
 rtl/v_hier_drv.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/v_hier_drv.sv
// ---------------------------------------------------------------------------
// v_hier_drv
//   Stimulus/response driver and checker for the avec -> qvec interface of a
//   device under stimulus (v_hier_sub in hierarchy tests). One run sequences
//   NVEC vectors onto avec. Each vector is held for LAT+1 cycles
//   (DRIVE, LAT-1 WAITs, CHECK). In the CHECK cycle qvec is compared against
//   exp_q, and mismatches are counted.
//
// Optional build macro: V_HIER_DRV_LFSR_EN
//   defined   : vectors come from a Fibonacci LFSR that starts at LFSR_SEED
//   undefined : vectors are a wrapping counter 0,1,2,...; LFSR_SEED unused
//
// Parameters
//   WIDTH     width of avec/qvec/exp_q
//   NVEC      vectors per run, 1..2**16
//   LAT       cycles from avec change to qvec sample, >= 1
//   ERRW      width of the saturating error counter
//   LFSR_SEED first LFSR vector (LFSR build only), nonzero
//
// Ports
//   clk       in   clock, rising edge
//   rst       in   asynchronous reset, active-high
//   start     in   begin a run (sampled only in IDLE)
//   qvec      in   response from the device under stimulus
//   exp_q     in   expected response, valid in the CHECK cycle
//   avec      out  stimulus vector
//   busy      out  high from the cycle after start until DONE exits
//   done      out  one-cycle pulse at the end of a run
//   err_cnt   out  mismatch count for the current/last run
//   first_err out  index of the first mismatching vector, 16'hFFFF if none
// ---------------------------------------------------------------------------
module v_hier_drv #(
    parameter int unsigned      WIDTH     = 4,
    parameter int unsigned      NVEC      = 16,
    parameter int unsigned      LAT       = 2,
    parameter int unsigned      ERRW      = 8,
    parameter logic [WIDTH-1:0] LFSR_SEED = 4'h1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] qvec,
    input  logic [WIDTH-1:0] exp_q,
    output logic [WIDTH-1:0] avec,
    output logic             busy,
    output logic             done,
    output logic [ERRW-1:0]  err_cnt,
    output logic [15:0]      first_err
);

    // Wait counter only has to hold LAT-1.
    localparam int unsigned CW = (LAT > 1) ? $clog2(LAT) : 1;
    localparam logic [ERRW-1:0] ERR_MAX  = {ERRW{1'b1}};
    localparam logic [15:0]     NO_ERR   = 16'hFFFF;
    localparam logic [15:0]     LAST_IDX = 16'(NVEC - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DRIVE,
        S_WAIT,
        S_CHECK,
        S_DONE
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [WIDTH-1:0] r_avec;
    logic [ERRW-1:0]  r_err_cnt;
    logic [15:0]      r_first_err;
    logic [15:0]      r_idx;
    logic [CW-1:0]    r_wait;
    logic [WIDTH-1:0] w_first_vec;
    logic [WIDTH-1:0] w_next_vec;

    // Vector pattern generator.
`ifdef V_HIER_DRV_LFSR_EN
    assign w_first_vec = LFSR_SEED;
    assign w_next_vec  = {r_avec[WIDTH-2:0], r_avec[WIDTH-1] ^ r_avec[0]};
`else
    logic w_unused_seed;
    assign w_unused_seed = ^LFSR_SEED;   // seed only matters for the LFSR pattern
    assign w_first_vec   = '0;
    assign w_next_vec    = r_avec + WIDTH'(1);
`endif

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_next = S_DRIVE;
            S_DRIVE: w_state_next = (LAT > 1) ? S_WAIT : S_CHECK;
            // The counter reaches zero on this transition, giving LAT-1 WAITs.
            S_WAIT:  if (r_wait == CW'(1)) w_state_next = S_CHECK;
            S_CHECK: w_state_next = (r_idx == LAST_IDX) ? S_DONE : S_DRIVE;
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Output logic.
    always_comb begin
        busy = (r_state != S_IDLE);
        done = (r_state == S_DONE);
    end

    // Datapath: vector, index, wait counter and error bookkeeping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_avec      <= '0;
            r_err_cnt   <= '0;
            r_first_err <= NO_ERR;
            r_idx       <= '0;
            r_wait      <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_avec      <= w_first_vec;
                        r_err_cnt   <= '0;
                        r_first_err <= NO_ERR;
                        r_idx       <= '0;
                    end
                end
                S_DRIVE: r_wait <= CW'(LAT - 1);
                S_WAIT:  r_wait <= r_wait - CW'(1);
                S_CHECK: begin
                    // Written as if/else so an unknown compare result in
                    // simulation falls into the mismatch branch.
                    if (qvec == exp_q) begin
                    end else begin
                        if (r_err_cnt != ERR_MAX) begin
                            r_err_cnt <= r_err_cnt + ERRW'(1);
                        end
                        if (r_first_err == NO_ERR) begin
                            r_first_err <= r_idx;
                        end
                    end
                    if (r_idx != LAST_IDX) begin
                        r_idx  <= r_idx + 16'd1;
                        r_avec <= w_next_vec;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign avec      = r_avec;
    assign err_cnt   = r_err_cnt;
    assign first_err = r_first_err;

endmodule
